// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB/I2C register target.
// Holds the protocol state enum, default device address and R/W encoding.
package sccb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEVADDR,
    ACK_DEV,
    REG_HI,
    ACK_HI,
    REG_LO,
    ACK_LO,
    WR_DATA,
    ACK_WR,
    RD_DATA,
    RD_ACK,
    IGNORE
  } sccb_state_t;

  localparam logic [6:0] SCCB_DEV_ADDR = 7'h3C;
  localparam logic       SCCB_RW_READ  = 1'b1;

endpackage

// File: rtl/sccb_target_i2c_line_filter.sv
// SCL/SDA conditioning: 2-FF synchronizer, FILTER_LEN-sample glitch filter,
// and registered SCL rise/fall plus START/STOP pulses. Ports: clk_i, rst_i,
// scl_i, sda_i in; filtered sda_o level and one-cycle event pulses out.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0]            scl_sync_q;
  logic [1:0]            sda_sync_q;
  logic [FILTER_LEN-1:0] scl_hist_q;
  logic [FILTER_LEN-1:0] sda_hist_q;
  logic                  scl_q, scl_d;
  logic                  sda_q, sda_d;
  logic                  rise_q, fall_q;
  logic                  start_q, stop_q;

  // A level is accepted only once the whole sample window agrees.
  always_comb begin
    scl_d = scl_q;
    sda_d = sda_q;
    if (&scl_hist_q)       scl_d = 1'b1;
    else if (~|scl_hist_q) scl_d = 1'b0;
    if (&sda_hist_q)       sda_d = 1'b1;
    else if (~|sda_hist_q) sda_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_hist_q <= {scl_hist_q[FILTER_LEN-2:0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[FILTER_LEN-2:0], sda_sync_q[1]};
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      rise_q     <= scl_d & ~scl_q;
      fall_q     <= ~scl_d & scl_q;
      // Bus conditions need SCL high both before and after the SDA edge.
      start_q    <= scl_q & scl_d & sda_q & ~sda_d;
      stop_q     <= scl_q & scl_d & ~sda_q & sda_d;
    end
  end

  assign sda_o      = sda_q;
  assign scl_rise_o = rise_q;
  assign scl_fall_o = fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;

endmodule

// File: rtl/sccb_target.sv
// SCCB/I2C target: 7-bit address, 16-bit register pointer, 8-bit data.
// Ports: clk_camera/sys_rst_camera, scl_i/sda_i bus inputs, sda_o/sda_t
// open-drain drive, reg_wr_* write strobe, reg_rd_* read port, busy.
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = SCCB_DEV_ADDR,
  parameter int         FILTER_LEN  = 3,
  parameter int         HOLD_CYCLES = 4
) (
  input  logic        clk_camera,
  input  logic        sys_rst_camera,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_t,
  output logic        reg_wr_valid,
  output logic [15:0] reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic [15:0] reg_rd_addr,
  output logic        reg_rd_req,
  input  logic [7:0]  reg_rd_data,
  output logic        busy
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  logic sda_lvl, rise_p, fall_p, start_p, stop_p;

  i2c_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filt (
    .clk_i      (clk_camera),
    .rst_i      (sys_rst_camera),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_lvl),
    .scl_rise_o (rise_p),
    .scl_fall_o (fall_p),
    .start_o    (start_p),
    .stop_o     (stop_p)
  );

  sccb_state_t     state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hi_q, hi_d;
  logic [15:0]     ptr_q, ptr_d;
  logic [7:0]      tx_q, tx_d;
  logic            sda_t_q, sda_t_d;
  logic            pend_q, pend_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            busy_q, busy_d;
  logic            wr_valid_q, wr_valid_d;
  logic [15:0]     wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            rd_req_q, rd_req_d;
  logic            rd_pend_q;
  logic            rd_mode_q, rd_mode_d;
  logic [7:0]      byte_in;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    hi_d       = hi_q;
    ptr_d      = ptr_q;
    tx_d       = tx_q;
    sda_t_d    = sda_t_q;
    pend_d     = pend_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_req_d   = 1'b0;
    rd_mode_d  = rd_mode_q;
    byte_in    = {shift_q[6:0], sda_lvl};

    // Read data is valid the cycle after the request strobe.
    if (rd_pend_q) tx_d = reg_rd_data;

    // Deferred SDA change: applied HOLD_CYCLES after the SCL fall.
    if (hold_q != '0) begin
      hold_d = hold_q - HOLD_ONE;
      if (hold_q == HOLD_ONE) sda_t_d = pend_q;
    end

    if (start_p) begin
      state_d   = DEVADDR;
      bit_cnt_d = '0;
      busy_d    = 1'b1;
      sda_t_d   = 1'b1;
      hold_d    = '0;
    end else if (stop_p) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      busy_d    = 1'b0;
      sda_t_d   = 1'b1;
      hold_d    = '0;
    end else if (rise_p) begin
      unique case (state_q)
        DEVADDR, REG_HI, REG_LO, WR_DATA: begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            unique case (state_q)
              DEVADDR: begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state_d   = ACK_DEV;
                  rd_mode_d = (byte_in[0] == SCCB_RW_READ);
                end else begin
                  state_d = IGNORE;
                end
              end
              REG_HI: begin
                hi_d    = byte_in;
                state_d = ACK_HI;
              end
              REG_LO: begin
                ptr_d   = {hi_q, byte_in};
                state_d = ACK_LO;
              end
              default: begin
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = byte_in;
                ptr_d      = ptr_q + 16'd1;
                state_d    = ACK_WR;
              end
            endcase
          end
        end
        ACK_DEV, ACK_HI, ACK_LO, ACK_WR: begin
          bit_cnt_d = 3'd1;
          if (state_q == ACK_DEV && rd_mode_q) rd_req_d = 1'b1;
        end
        RD_DATA: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            ptr_d   = ptr_q + 16'd1;
            state_d = RD_ACK;
          end
        end
        RD_ACK: begin
          if (!sda_lvl) begin
            rd_req_d  = 1'b1;
            bit_cnt_d = 3'd1;
          end else begin
            state_d = IGNORE;
          end
        end
        default: ;
      endcase
    end else if (fall_p) begin
      unique case (state_q)
        ACK_DEV, ACK_HI, ACK_LO, ACK_WR: begin
          hold_d = HOLD_INIT;
          if (bit_cnt_q == 3'd0) begin
            pend_d = 1'b0;
          end else begin
            bit_cnt_d = '0;
            pend_d    = 1'b1;
            unique case (state_q)
              ACK_DEV: begin
                if (rd_mode_q) begin
                  state_d = RD_DATA;
                  pend_d  = tx_q[7];
                end else begin
                  state_d = REG_HI;
                end
              end
              ACK_HI:  state_d = REG_LO;
              default: state_d = WR_DATA;
            endcase
          end
        end
        RD_DATA: begin
          if (bit_cnt_q != 3'd0) begin
            tx_d   = {tx_q[6:0], 1'b1};
            pend_d = tx_q[6];
            hold_d = HOLD_INIT;
          end
        end
        RD_ACK: begin
          hold_d = HOLD_INIT;
          if (bit_cnt_q == 3'd0) begin
            pend_d = 1'b1;
          end else begin
            bit_cnt_d = '0;
            state_d   = RD_DATA;
            pend_d    = tx_q[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_camera or posedge sys_rst_camera) begin
    if (sys_rst_camera) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      hi_q       <= '0;
      ptr_q      <= '0;
      tx_q       <= '1;
      sda_t_q    <= 1'b1;
      pend_q     <= 1'b1;
      hold_q     <= '0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_req_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_mode_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      hi_q       <= hi_d;
      ptr_q      <= ptr_d;
      tx_q       <= tx_d;
      sda_t_q    <= sda_t_d;
      pend_q     <= pend_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_req_q   <= rd_req_d;
      rd_pend_q  <= rd_req_q;
      rd_mode_q  <= rd_mode_d;
    end
  end

  // A bus condition releases SDA in the cycle it is detected.
  assign sda_t        = sda_t_q | start_p | stop_p;
  assign sda_o        = 1'b0;
  assign reg_wr_valid = wr_valid_q;
  assign reg_wr_addr  = wr_addr_q;
  assign reg_wr_data  = wr_data_q;
  assign reg_rd_addr  = ptr_q;
  assign reg_rd_req   = rd_req_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sccb_target.sv
// Self-checking bench for sccb_target: open-drain bus master model,
// table of write transactions, hand sequences for read and disturbances.
module tb_sccb_target;

  localparam int Q = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        scl_m, sda_m, glitch;
  logic        sda_line, sda_in;
  logic        sda_o, sda_t, wr_valid, rd_req, busy;
  logic [15:0] wr_addr, rd_addr;
  logic [7:0]  wr_data, rd_data;

  always #5 clk = ~clk;

  assign sda_line = sda_m & (sda_t | sda_o);
  assign sda_in   = sda_line & ~glitch;

  always_comb begin
    case (rd_addr)
      16'h300A: rd_data = 8'h56;
      16'h300B: rd_data = 8'h40;
      default:  rd_data = 8'hA5;
    endcase
  end

  sccb_target dut (
    .clk_camera     (clk),
    .sys_rst_camera (rst),
    .scl_i          (scl_m),
    .sda_i          (sda_in),
    .sda_o          (sda_o),
    .sda_t          (sda_t),
    .reg_wr_valid   (wr_valid),
    .reg_wr_addr    (wr_addr),
    .reg_wr_data    (wr_data),
    .reg_rd_addr    (rd_addr),
    .reg_rd_req     (rd_req),
    .reg_rd_data    (rd_data),
    .busy           (busy)
  );

  logic [15:0] wa[$];
  logic [7:0]  wd[$];
  int          n_rd = 0;
  int          drv_cnt = 0;

  always @(negedge clk) begin
    if (wr_valid) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
    if (rd_req) n_rd = n_rd + 1;
    if (!sda_t) drv_cnt = drv_cnt + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    s = sda_line;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic bus_start;
    sda_m = 1'b1;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b0;
    tick(Q);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0;
    tick(Q);
    scl_m = 1'b1;
    tick(Q);
    sda_m = 1'b1;
    tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, s);
      d = {d[6:0], s};
    end
    clk_bit(~mack, s);
  endtask

  typedef struct {
    int              n;
    logic [0:5][7:0] b;
    logic [0:5]      ack;
    int              nstb;
    logic [15:0]     a0;
    logic [15:0]     ptr;
    logic            drive;
  } vec_t;

  vec_t vt[4];

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int          w0, d0, r0;
    logic        a, s;
    logic [7:0]  d;
    logic [15:0] ea;

    vt[0] = '{4, {8'h78, 8'h35, 8'h01, 8'h0A, 8'h00, 8'h00},
              6'b111100, 1, 16'h3501, 16'h3502, 1'b1};
    vt[1] = '{4, {8'h42, 8'h35, 8'h01, 8'h0A, 8'h00, 8'h00},
              6'b000000, 0, 16'h0000, 16'h3502, 1'b0};
    vt[2] = '{6, {8'h78, 8'h35, 8'h01, 8'h01, 8'h02, 8'h03},
              6'b111111, 3, 16'h3501, 16'h3504, 1'b1};
    vt[3] = '{5, {8'h78, 8'hFF, 8'hFF, 8'h11, 8'h22, 8'h00},
              6'b111110, 2, 16'hFFFF, 16'h0001, 1'b1};

    rst = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    glitch = 1'b0;
    tick(5);
    chk("rst_sda_t", sda_t, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick(10);
    chk("idle_sda_t", sda_t, 1);
    chk("idle_sda_o", sda_o, 0);
    chk("idle_wr_valid", wr_valid, 0);
    chk("idle_rd_req", rd_req, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ptr", rd_addr, 0);

    for (int r = 0; r < 4; r++) begin
      w0 = wa.size();
      d0 = drv_cnt;
      bus_start;
      chk($sformatf("r%0d_busy", r), busy, 1);
      for (int k = 0; k < vt[r].n; k++) begin
        wr_byte(vt[r].b[k], a);
        chk($sformatf("r%0d_ack%0d", r, k), a, vt[r].ack[k]);
      end
      bus_stop;
      tick(10);
      chk($sformatf("r%0d_nstb", r), wa.size() - w0, vt[r].nstb);
      for (int i = 0; i < vt[r].nstb; i++) begin
        ea = vt[r].a0 + 16'(i);
        if (w0 + i < wa.size()) begin
          chk($sformatf("r%0d_waddr%0d", r, i), wa[w0+i], ea);
          chk($sformatf("r%0d_wdata%0d", r, i), wd[w0+i], vt[r].b[3+i]);
        end
      end
      chk($sformatf("r%0d_ptr", r), rd_addr, vt[r].ptr);
      chk($sformatf("r%0d_busy_end", r), busy, 0);
      chk($sformatf("r%0d_drive", r), drv_cnt != d0, vt[r].drive);
    end

    // Pointer write, repeated START, two-byte read.
    r0 = n_rd;
    bus_start;
    wr_byte(8'h78, a); chk("rd_ack_dev_w", a, 1);
    wr_byte(8'h30, a); chk("rd_ack_hi", a, 1);
    wr_byte(8'h0A, a); chk("rd_ack_lo", a, 1);
    bus_start;
    chk("rd_ptr_kept", rd_addr, 16'h300A);
    wr_byte(8'h79, a); chk("rd_ack_dev_r", a, 1);
    rd_byte(1'b1, d); chk("rd_byte0", d, 8'h56);
    rd_byte(1'b0, d); chk("rd_byte1", d, 8'h40);
    bus_stop;
    tick(10);
    chk("rd_req_count", n_rd - r0, 2);
    chk("rd_ptr_end", rd_addr, 16'h300C);
    chk("rd_busy_end", busy, 0);

    // STOP after five data bits.
    w0 = wa.size();
    bus_start;
    wr_byte(8'h78, a);
    wr_byte(8'h12, a);
    wr_byte(8'h34, a);
    for (int i = 0; i < 5; i++) clk_bit(i[0], s);
    bus_stop;
    tick(10);
    chk("part_nstb", wa.size() - w0, 0);
    chk("part_ptr", rd_addr, 16'h1234);
    chk("part_busy", busy, 0);
    chk("part_sda_t", sda_t, 1);

    // One-cycle SDA glitch while idle must not look like START.
    glitch = 1'b1;
    tick(1);
    glitch = 1'b0;
    tick(20);
    chk("glitch_busy", busy, 0);

    // Reset while the target is acknowledging its address.
    w0 = wa.size();
    bus_start;
    for (int i = 7; i >= 0; i--) clk_bit(i == 6 || i == 5 || i == 4 || i == 3, s);
    chk("pre_rst_ack", sda_t, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_sda_t", sda_t, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ptr", rd_addr, 0);
    tick(3);
    rst = 1'b0;
    tick(2);
    d0 = drv_cnt;
    clk_bit(1'b1, s);
    chk("post_rst_noack", s, 1);
    for (int i = 0; i < 8; i++) clk_bit(1'b0, s);
    bus_stop;
    tick(10);
    chk("post_rst_drive", drv_cnt - d0, 0);
    chk("post_rst_nstb", wa.size() - w0, 0);

    // Normal operation resumes with the next START.
    bus_start;
    wr_byte(8'h78, a);
    chk("recover_ack", a, 1);
    bus_stop;
    tick(10);
    chk("recover_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
